// File: rtl/ff_arb_pkg.sv
// Shared types and helpers for the ff_write_arbiter slice: FSM state encoding,
// default sizing and the rotating-priority winner search.
package ff_arb_pkg;

  localparam int unsigned N_DEF = 4;
  localparam int unsigned W_DEF = 8;
  localparam int unsigned MAX_N = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_e;

  // Returns the first set request at or after ptr, wrapping modulo n.
  // A constant n lets synthesis unroll this into a small priority mux.
  function automatic int unsigned rr_pick(input logic [MAX_N-1:0] req,
                                          input int unsigned      ptr,
                                          input int unsigned      n);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned k = 0; k < MAX_N; k++) begin
      idx = (ptr + k) % n;
      if (k < n && !found && req[idx[IDX_W-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ff_write_arbiter_reg.sv
// Enable-gated shared storage register with complement output.
// Priority: synchronous reset, then enable, then hold.
module ff_en_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] q_n
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

  assign q_n = ~q;

endmodule

// File: rtl/ff_write_arbiter.sv
// Round-robin write arbiter owning the shared ff_en_reg's D and en.
// Define FF_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module ff_write_arbiter
  import ff_arb_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wr_data,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   ack,
  output logic           busy,
  output logic [W-1:0]   q,
  output logic [W-1:0]   q_n
);

  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  state_e            state, state_nxt;
  logic              load, commit;
  logic [ID_W-1:0]   id, win, ptr;
  logic [W-1:0]      data_lat;
  logic [MAX_N-1:0]  req_ext;
  logic [N-1:0]      id_onehot;

  assign req_ext = MAX_N'(req);
  assign win     = ID_W'(rr_pick(req_ext, 32'(ptr), N));

`ifdef FF_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (reset)       rr_ptr <= '0;
    else if (commit) rr_ptr <= (id == ID_W'(N-1)) ? '0 : id + ID_W'(1);
  end

  assign ptr = rr_ptr;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          load      = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        // A reset landing in GRANT discards the write and suppresses the ack.
        commit    = !reset;
        state_nxt = RELEASE;
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id       <= '0;
      data_lat <= '0;
    end else if (load) begin
      id       <= win;
      data_lat <= wr_data[win*W +: W];
    end
  end

  assign id_onehot = N'(1) << id;
  assign grant     = commit ? id_onehot : '0;
  assign ack       = commit ? id_onehot : '0;
  assign busy      = (state != IDLE);

  ff_en_reg #(.W(W)) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (commit),
    .d     (data_lat),
    .q     (q),
    .q_n   (q_n)
  );

endmodule

// File: tb/tb_ff_write_arbiter.sv
// Directed self-checking bench for ff_write_arbiter (N=4, W=8); honours
// FF_ARB_FIXED_PRIO_EN for the expected winners.
module tb_ff_write_arbiter;

  localparam int N = 4;
  localparam int W = 8;

`ifdef FF_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wr_data;
  logic [N-1:0]   grant, ack;
  logic           busy;
  logic [W-1:0]   q, q_n;

  int n_cmp = 0;
  int n_err = 0;

  ff_write_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_data (wr_data),
    .grant   (grant),
    .ack     (ack),
    .busy    (busy),
    .q       (q),
    .q_n     (q_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; observation happens 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] exp_oh;
    int           exp_id;

    reset   = 1'b1;
    req     = '0;
    wr_data = '0;

    // Reset then single request from requester 1.
    tick();
    check("rst_q",     32'(q),     32'h00);
    check("rst_qn",    32'(q_n),   32'hFF);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_ack",   32'(ack),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    tick();
    reset   = 1'b0;
    req     = 4'b0010;
    wr_data = 32'h0000_A500;
    check("idle_ack",  32'(ack),  32'h0);
    check("idle_busy", 32'(busy), 32'h0);
    tick();
    check("single_ack",   32'(ack),   32'b0010);
    check("single_grant", 32'(grant), 32'b0010);
    check("single_busy1", 32'(busy),  32'h1);
    req = '0;
    tick();
    check("single_ack_off", 32'(ack),  32'h0);
    check("single_busy2",   32'(busy), 32'h1);
    check("single_q",       32'(q),    32'hA5);
    check("single_qn",      32'(q_n),  32'h5A);
    tick();
    check("single_busy_end", 32'(busy), 32'h0);

    // Contention from a fresh pointer: commits 0,1,2,3,0 every 3 cycles.
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    req     = 4'b1111;
    wr_data = 32'h0302_0100;
    for (int k = 0; k < 5; k++) begin
      exp_id = FIXED ? 0 : (k % N);
      exp_oh = 4'b0001 << exp_id;
      tick();
      check($sformatf("cont_ack%0d", k), 32'(ack), 32'(exp_oh));
      tick();
      check($sformatf("cont_q%0d", k), 32'(q), 32'(exp_id));
      tick();
      check($sformatf("cont_gap%0d", k), 32'(ack), 32'h0);
    end
    req = '0;
    tick();

    // Wrap: requester 3 commits, then 1001 must go to requester 0.
    req     = 4'b1000;
    wr_data = 32'h3300_0044;
    tick();
    check("wrap_ack3", 32'(ack), 32'b1000);
    req = 4'b1001;
    tick();
    tick();
    tick();
    check("wrap_ack0", 32'(ack), 32'b0001);
    req = '0;
    tick();
    check("wrap_q", 32'(q), 32'h44);
    tick();

    // Data capture: a change after arbitration must not reach q.
    req     = 4'b0100;
    wr_data = 32'h0011_0000;
    tick();
    check("cap_ack", 32'(ack), 32'b0100);
    wr_data = 32'h00FF_0000;
    tick();
    check("cap_q", 32'(q), 32'h11);
    req = '0;
    tick();

    // Reset during GRANT: write dropped, no ack, pointer back to 0.
    req     = 4'b1111;
    wr_data = 32'h0302_0100;
    tick();
    check("rg_pre_ack", 32'(ack), FIXED ? 32'b0001 : 32'b1000);
    reset = 1'b1;
    req   = '0;
    #1;
    check("rg_ack_gated", 32'(ack), 32'h0);
    tick();
    reset = 1'b0;
    check("rg_ack",   32'(ack),   32'h0);
    check("rg_grant", 32'(grant), 32'h0);
    check("rg_q",     32'(q),     32'h00);
    check("rg_qn",    32'(q_n),   32'hFF);
    check("rg_busy",  32'(busy),  32'h0);
    req = 4'b1111;
    tick();
    check("rg_ptr0", 32'(ack), 32'b0001);
    req = '0;
    tick();
    check("rg_q_after", 32'(q), 32'h00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
